// File: rtl/pipe_dmem_arbiter_if.sv
// pipe_dmem_arbiter_if: CPU MEM-stage, debug/loader and data-RAM signals of the dmem arbiter.
// master = environment (pipeline, debug port, RAM); slave = the arbiter.
interface pipe_dmem_arbiter_if #(
   parameter int AW = 10
);
   logic          cpu_req;
   logic          cpu_we;
   logic [31:0]   cpu_addr;
   logic [31:0]   cpu_wdata;
   logic [31:0]   cpu_rdata;
   logic          cpu_stall;
   logic          dbg_req;
   logic          dbg_we;
   logic [AW-1:0] dbg_addr;
   logic [31:0]   dbg_wdata;
   logic          dbg_ack;
   logic [31:0]   dbg_rdata;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata;
   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, dbg_req, dbg_we, dbg_addr, dbg_wdata, mem_rdata,
      input  cpu_rdata, cpu_stall, dbg_ack, dbg_rdata, mem_en, mem_we, mem_addr, mem_wdata
   );
   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, dbg_req, dbg_we, dbg_addr, dbg_wdata, mem_rdata,
      output cpu_rdata, cpu_stall, dbg_ack, dbg_rdata, mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/pipe_dmem_arbiter.sv
// pipe_dmem_arbiter: shares one synchronous data RAM between the MEM stage and a debug port.
// Define DMEM_ARB_STARVE_EN to force a debug grant after STARVE_LIMIT lost arbitration cycles.
module pipe_dmem_arbiter #(
   parameter int AW           = 10,
   parameter int STARVE_LIMIT = 4
) (
   input logic                clock,
   input logic                reset,
   pipe_dmem_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, CRD, DBG} state_t;
   state_t      state_q, state_d;
   logic [31:0] dbg_rdata_q, dbg_rdata_d;
   logic        idle, forced, dbg_win, cpu_win, dbg_rd;
   logic        unused;
`ifdef DMEM_ARB_STARVE_EN
   logic [7:0]  cnt_q, cnt_d;
   assign unused = ^{bus.cpu_addr[31:AW+2], bus.cpu_addr[1:0]};
   assign forced = bus.dbg_req && cnt_q >= 8'(STARVE_LIMIT);
   // an IDLE cycle with dbg_req high that debug does not win is one the CPU won
   always_comb cnt_d = (!bus.dbg_req || (idle && dbg_win)) ? 8'd0 : (idle && cnt_q != 8'hff) ? cnt_q + 8'd1 : cnt_q;
   always_ff @(posedge clock) cnt_q <= reset ? 8'd0 : cnt_d;
`else
   assign unused = ^{bus.cpu_addr[31:AW+2], bus.cpu_addr[1:0], STARVE_LIMIT[0]};
   assign forced = 1'b0;
`endif
   always_comb begin
      idle          = !reset && state_q == IDLE;
      dbg_win       = bus.dbg_req && (!bus.cpu_req || forced);
      cpu_win       = bus.cpu_req && !dbg_win;
      dbg_rd        = !reset && state_q == DBG && !bus.dbg_we;
      bus.mem_en    = idle && (cpu_win || dbg_win);
      bus.mem_we    = bus.mem_en && (dbg_win ? bus.dbg_we : bus.cpu_we);
      bus.mem_addr  = !bus.mem_en ? '0 : dbg_win ? bus.dbg_addr : bus.cpu_addr[AW+1:2];
      bus.mem_wdata = !bus.mem_en ? '0 : dbg_win ? bus.dbg_wdata : bus.cpu_wdata;
      bus.cpu_stall = idle ? bus.cpu_req && (dbg_win || !bus.cpu_we) : !reset && state_q == DBG && bus.cpu_req;
      bus.cpu_rdata = (!reset && state_q == CRD) ? bus.mem_rdata : '0;
      bus.dbg_ack   = !reset && state_q == DBG;
      // read data is visible in the ack cycle itself, then held by the register
      dbg_rdata_d   = dbg_rd ? bus.mem_rdata : dbg_rdata_q;
      bus.dbg_rdata = reset ? '0 : dbg_rdata_d;
      state_d       = !idle ? IDLE : dbg_win ? DBG : (cpu_win && !bus.cpu_we) ? CRD : IDLE;
   end
   always_ff @(posedge clock) begin
      state_q     <= reset ? IDLE : state_d;
      dbg_rdata_q <= reset ? '0 : dbg_rdata_d;
   end
endmodule

// File: tb/tb_pipe_dmem_arbiter.sv
// tb_pipe_dmem_arbiter: directed vectors and corner sequences for pipe_dmem_arbiter.
module tb_pipe_dmem_arbiter;
`ifdef DMEM_ARB_STARVE_EN
   localparam bit STARVE = 1'b1;
`else
   localparam bit STARVE = 1'b0;
`endif
   localparam logic [31:0] DB = 32'hDEAD_BEEF;
   localparam logic [31:0] K  = 32'h1234_5678;
   typedef struct {
      logic        creq, cwe;
      logic [31:0] caddr, cwdata;
      logic        dreq, dwe;
      logic [9:0]  daddr;
      logic [31:0] dwdata;
      logic        e_stall, e_en, e_we;
      logic [9:0]  e_addr;
      logic        e_ack;
      logic [31:0] e_crd, e_drd;
   } vec_t;
   logic        clock = 1'b0;
   logic        reset;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] ram [0:1023];
   vec_t        v [16];
   pipe_dmem_arbiter_if #(.AW(10)) bus ();
   pipe_dmem_arbiter #(.AW(10), .STARVE_LIMIT(4)) dut (.clock(clock), .reset(reset), .bus(bus));
   always #5 clock = ~clock;
   always @(posedge clock)
      if (bus.mem_en) begin
         if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
         else bus.mem_rdata <= ram[bus.mem_addr];
      end
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic drive(input logic creq, input logic cwe, input logic [31:0] caddr, input logic [31:0] cwdata,
                        input logic dreq, input logic dwe, input logic [9:0] daddr, input logic [31:0] dwdata);
      bus.cpu_req = creq; bus.cpu_we = cwe; bus.cpu_addr = caddr; bus.cpu_wdata = cwdata;
      bus.dbg_req = dreq; bus.dbg_we = dwe; bus.dbg_addr = daddr; bus.dbg_wdata = dwdata;
   endtask
   task automatic tick();
      @(posedge clock);
      #1;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
   initial begin
      for (int i = 0; i < 1024; i++) ram[i] = '0;
      //        creq  cwe   caddr          cwdata        dreq  dwe   daddr  dwdata   stall en    we    addr   ack   crd    drd
      v[0]  = '{1'b1, 1'b1, 32'h10,        DB,           1'b0, 1'b0, 10'd0, 32'd0,   1'b0, 1'b1, 1'b1, 10'd4, 1'b0, 32'd0, 32'd0};
      v[1]  = '{1'b1, 1'b0, 32'h10,        32'd0,        1'b0, 1'b0, 10'd0, 32'd0,   1'b1, 1'b1, 1'b0, 10'd4, 1'b0, 32'd0, 32'd0};
      v[2]  = '{1'b1, 1'b0, 32'h10,        32'd0,        1'b0, 1'b0, 10'd0, 32'd0,   1'b0, 1'b0, 1'b0, 10'd0, 1'b0, DB,    32'd0};
      v[3]  = '{1'b0, 1'b0, 32'd0,         32'd0,        1'b1, 1'b0, 10'd4, 32'd0,   1'b0, 1'b1, 1'b0, 10'd4, 1'b0, 32'd0, 32'd0};
      v[4]  = '{1'b0, 1'b0, 32'd0,         32'd0,        1'b1, 1'b0, 10'd4, 32'd0,   1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 32'd0, DB};
      v[5]  = '{1'b0, 1'b0, 32'd0,         32'd0,        1'b0, 1'b0, 10'd0, 32'd0,   1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 32'd0, DB};
      v[6]  = '{1'b0, 1'b0, 32'd0,         32'd0,        1'b1, 1'b1, 10'd7, K,       1'b0, 1'b1, 1'b1, 10'd7, 1'b0, 32'd0, DB};
      v[7]  = '{1'b0, 1'b0, 32'd0,         32'd0,        1'b1, 1'b1, 10'd7, K,       1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 32'd0, DB};
      v[8]  = '{1'b1, 1'b0, 32'hFFFF_F01C, 32'd0,        1'b0, 1'b0, 10'd0, 32'd0,   1'b1, 1'b1, 1'b0, 10'd7, 1'b0, 32'd0, DB};
      v[9]  = '{1'b1, 1'b0, 32'hFFFF_F01C, 32'd0,        1'b0, 1'b0, 10'd0, 32'd0,   1'b0, 1'b0, 1'b0, 10'd0, 1'b0, K,     DB};
      v[10] = '{1'b1, 1'b0, 32'h10,        32'd0,        1'b1, 1'b0, 10'd7, 32'd0,   1'b1, 1'b1, 1'b0, 10'd4, 1'b0, 32'd0, DB};
      v[11] = '{1'b1, 1'b0, 32'h10,        32'd0,        1'b1, 1'b0, 10'd7, 32'd0,   1'b0, 1'b0, 1'b0, 10'd0, 1'b0, DB,    DB};
      v[12] = '{1'b0, 1'b0, 32'd0,         32'd0,        1'b1, 1'b0, 10'd7, 32'd0,   1'b0, 1'b1, 1'b0, 10'd7, 1'b0, 32'd0, DB};
      v[13] = '{1'b1, 1'b1, 32'h20,        32'hA5A5,     1'b1, 1'b0, 10'd7, 32'd0,   1'b1, 1'b0, 1'b0, 10'd0, 1'b1, 32'd0, K};
      v[14] = '{1'b1, 1'b1, 32'h20,        32'hA5A5,     1'b0, 1'b0, 10'd0, 32'd0,   1'b0, 1'b1, 1'b1, 10'd8, 1'b0, 32'd0, K};
      v[15] = '{1'b0, 1'b0, 32'd0,         32'd0,        1'b0, 1'b0, 10'd0, 32'd0,   1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 32'd0, K};
      // reset gates every output even with both requesters active
      reset = 1'b1;
      drive(1'b1, 1'b0, 32'h10, 32'd0, 1'b1, 1'b0, 10'd4, 32'd0);
      @(posedge clock);
      @(negedge clock);
      chk("rst_en", bus.mem_en, 1'b0);
      chk("rst_we", bus.mem_we, 1'b0);
      chk("rst_stall", bus.cpu_stall, 1'b0);
      chk("rst_ack", bus.dbg_ack, 1'b0);
      chk("rst_drd", bus.dbg_rdata, 32'd0);
      tick();
      reset = 1'b0;
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0);
      for (int i = 0; i < 16; i++) begin
         drive(v[i].creq, v[i].cwe, v[i].caddr, v[i].cwdata, v[i].dreq, v[i].dwe, v[i].daddr, v[i].dwdata);
         @(negedge clock);
         chk($sformatf("v%0d_stall", i), bus.cpu_stall, v[i].e_stall);
         chk($sformatf("v%0d_en", i), bus.mem_en, v[i].e_en);
         chk($sformatf("v%0d_we", i), bus.mem_we, v[i].e_we);
         chk($sformatf("v%0d_addr", i), bus.mem_addr, v[i].e_addr);
         chk($sformatf("v%0d_ack", i), bus.dbg_ack, v[i].e_ack);
         chk($sformatf("v%0d_crd", i), bus.cpu_rdata, v[i].e_crd);
         chk($sformatf("v%0d_drd", i), bus.dbg_rdata, v[i].e_drd);
         tick();
      end
      // back-to-back CPU stores against a pending debug write; request drops for one cycle after ack
      for (int i = 0; i < 13; i++) begin
         logic        iss, ack;
         logic [31:0] ea;
         iss = STARVE && (i == 4 || i == 11);
         ack = STARVE && (i == 5 || i == 12);
         ea  = iss ? 32'd20 : ack ? 32'd0 : 32'(64 + i);
         drive(1'b1, 1'b1, 32'(32'h100 + 4 * i), 32'(i), i != 6, 1'b1, 10'd20, 32'h55);
         @(negedge clock);
         chk($sformatf("starve%0d_stall", i), bus.cpu_stall, iss || ack);
         chk($sformatf("starve%0d_ack", i), bus.dbg_ack, ack);
         chk($sformatf("starve%0d_addr", i), bus.mem_addr, ea);
         tick();
      end
      // once the CPU goes quiet debug is granted immediately
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 10'd21, 32'h77);
      begin
         int n = 0;
         while (!bus.dbg_ack && n < 4) begin
            tick();
            n++;
         end
         chk("release_wait", n, 1);
      end
      tick();
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0);
      chk("release_ram", ram[21], 32'h77);
      // reset landing in the DBG cycle abandons the read
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 10'd4, 32'd0);
      @(negedge clock);
      chk("rdbg_issue_en", bus.mem_en, 1'b1);
      chk("rdbg_issue_drd", bus.dbg_rdata, K);
      tick();
      reset = 1'b1;
      bus.cpu_req = 1'b1;
      @(negedge clock);
      chk("rdbg_ack", bus.dbg_ack, 1'b0);
      chk("rdbg_stall", bus.cpu_stall, 1'b0);
      chk("rdbg_en", bus.mem_en, 1'b0);
      chk("rdbg_drd", bus.dbg_rdata, 32'd0);
      tick();
      reset = 1'b0;
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0);
      @(negedge clock);
      chk("rpost_ack", bus.dbg_ack, 1'b0);
      chk("rpost_en", bus.mem_en, 1'b0);
      chk("rpost_we", bus.mem_we, 1'b0);
      chk("rpost_stall", bus.cpu_stall, 1'b0);
      chk("rpost_crd", bus.cpu_rdata, 32'd0);
      chk("rpost_drd", bus.dbg_rdata, 32'd0);
      tick();
      drive(1'b1, 1'b1, 32'h30, 32'h5, 1'b0, 1'b0, 10'd0, 32'd0);
      @(negedge clock);
      chk("rpost_store_en", bus.mem_en, 1'b1);
      chk("rpost_store_we", bus.mem_we, 1'b1);
      chk("rpost_store_addr", bus.mem_addr, 32'd12);
      chk("rpost_store_stall", bus.cpu_stall, 1'b0);
      tick();
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0);
      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/pipe_dmem_arbiter.md
# pipe_dmem_arbiter

Single-port data-memory arbiter for the 5-stage pipelined CPU. It shares one synchronous data RAM between the MEM stage and a debug/loader port. It drives a pipeline-wide stall so the MEM stage can tolerate the RAM's one-cycle read latency, and it bounds debug starvation. It sits between the EX/MEM register outputs and the data RAM; its stall output freezes PC, IF/ID, ID/EX, EX/MEM and MEM/WB.

## Interface
- AW, 10, RAM word-address width (RAM depth 2^AW words of 32 bits)
- STARVE_LIMIT, 4, consecutive lost arbitration cycles before debug is forced through (range 1..255)

- clock  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- cpu_req  in  1  MEM stage holds a load or store
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  32  byte address; bits [AW+1:2] used, rest ignored
- cpu_wdata  in  32  store data
- cpu_rdata  out  32  load data, valid in CRD cycle
- cpu_stall  out  1  freeze entire pipeline this cycle
- dbg_req  in  1  level request, held until dbg_ack
- dbg_we  in  1  1 = write, 0 = read
- dbg_addr  in  AW  word address
- dbg_wdata  in  32  write data
- dbg_ack  out  1  one-cycle completion pulse
- dbg_rdata  out  32  read data; valid in ack cycle, held until next debug read completes
- mem_en  out  1  RAM access strobe
- mem_we  out  1  RAM write enable
- mem_addr  out  AW  RAM word address
- mem_wdata  out  32  RAM write data
- mem_rdata  in  32  RAM read data, valid the cycle after mem_en with mem_we=0

## Operation
- FSM states:
  - IDLE: arbitration; the only state that issues.
  - CRD: CPU read-data return.
  - DBG: debug completion.
- IDLE, CPU wins (cpu_req=1 and debug not forced):
  - Store: mem_en=mem_we=1, addr/data from CPU, cpu_stall=0; stay IDLE.
  - Load: mem_en=1, mem_we=0, cpu_stall=1; go CRD.
- CRD:
  - cpu_rdata=mem_rdata, cpu_stall=0; the pipeline latches the data at this edge.
  - No issue. The cpu_req still high is the same instruction and is ignored.
  - Go IDLE.
- IDLE, debug wins:
  - Issue debug access; cpu_stall=cpu_req; go DBG.
  - Debug wins when cpu_req=0 and dbg_req=1, or when forced.
- DBG:
  - dbg_ack=1; on reads, capture mem_rdata into the dbg_rdata register.
  - cpu_stall=cpu_req; go IDLE.
  - A dbg_req still high in the following IDLE is treated as a new request. The requester drops it in the cycle after ack.
- Starvation counter (8-bit):
  - Increments in each IDLE cycle where dbg_req=1 and the CPU wins.
  - Clears on debug grant or when dbg_req=0.
  - Forced = (count >= STARVE_LIMIT).
- cpu_rdata outside CRD: 0.
- Default output values:
  - mem_en, mem_we, dbg_ack: 0 unless stated.
  - mem_addr, mem_wdata: 0 when mem_en=0.

## Timing
- Reset values (while reset is high and after the edge where it is sampled):
  - state=IDLE, counter=0, dbg_rdata=0.
  - cpu_stall=0, dbg_ack=0, mem_en=0, mem_we=0.
- Reset is sampled at a rising edge and gates all outputs combinationally.
- CPU store: 0 stall cycles.
- CPU load: 1 stall cycle (issue cycle); data returns in the next cycle.
- Debug access: issue cycle, then ack cycle, so 2 cycles from grant.
- CPU stall while debug holds RAM: 2 cycles for a store, 3 for a load (debug 2 + load issue 1).
- Worst-case debug wait: STARVE_LIMIT arbitration cycles plus any CRD cycles in between.
- Reset mid-operation: the access is abandoned; no dbg_ack and no CRD return. RAM contents are untouched beyond writes already issued.
- Simultaneous CPU store and debug request, not forced: the store issues and the counter increments.

## Configuration
- Macro DMEM_ARB_STARVE_EN.
  - Defined: starvation counter and forced debug grant as above.
  - Undefined: no counter. Debug is granted only in IDLE with cpu_req=0, so debug can starve indefinitely. STARVE_LIMIT is ignored.

## Test plan
- Reset, then CPU store addr 0x0000_0010 data 0xDEAD_BEEF -> same cycle mem_en=1, mem_we=1, mem_addr=4, cpu_stall=0.
- CPU load addr 0x10 after that store -> cpu_stall=1 for 1 cycle, then cpu_rdata=0xDEADBEEF with cpu_stall=0.
- Debug read addr 4 with CPU idle -> dbg_ack 2 cycles after dbg_req rises; dbg_rdata=0xDEADBEEF and held after dbg_req drops.
- Continuous CPU stores plus dbg_req, STARVE_LIMIT=4, macro defined -> debug granted on the 5th IDLE cycle; cpu_stall=1 for 2 cycles; counter reads 0 afterwards. Same stimulus with macro undefined -> no dbg_ack while CPU stores continue.
- Reset asserted in DBG cycle -> no dbg_ack; next cycle state IDLE, all strobes 0.
- CPU load and dbg_req rising in the same IDLE cycle, not forced -> CPU issues and CRD follows; debug is granted in the next IDLE if cpu_req=0.
